data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory. Round-robin between
// a load/store port and a loader/debug port; one access every three cycles.
module data_mem_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;   // 1 = port 1 won most recently
  logic                win_q, win_d;     // owner of the access in flight
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                winner;

  // On a tie the port that did not win last time goes next.
  assign winner = (req0 && req1) ? ~last_q : req1;

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    last_d   = last_q;
    win_d    = win_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d = S_ACCESS;
          win_d   = winner;
          last_d  = winner;
          we_d    = winner ? we1    : we0;
          addr_d  = winner ? addr1  : addr0;
          wdata_d = winner ? wdata1 : wdata0;
        end
      end
      S_ACCESS: begin
        state_d = S_DONE;
        if (!we_q) begin
          if (win_q) rdata1_d = mem_rdata;
          else       rdata0_d = mem_rdata;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign gnt0  = (state_q != S_IDLE) && !win_q;
  assign gnt1  = (state_q != S_IDLE) &&  win_q;
  assign done0 = (state_q == S_DONE) && !win_q;
  assign done1 = (state_q == S_DONE) &&  win_q;

  // Gated by rst so an access aborted by reset never writes the memory.
  assign mem_read  = (state_q == S_ACCESS) && !we_q && !rst;
  assign mem_write = (state_q == S_ACCESS) &&  we_q && !rst;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small behavioural data memory
// (combinational read, synchronous write) attached to the memory side.
module tb_data_mem_arbiter;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, done0, done1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  logic [DATA_W-1:0] tb_mem [0:255];
  logic [5:0]        st;

  int n_vec = 0;
  int n_err = 0;

  data_mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = tb_mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_write) tb_mem[mem_addr[7:0]] <= mem_wdata;

  // {gnt0, gnt1, done0, done1, mem_read, mem_write}
  assign st = {gnt0, gnt1, done0, done1, mem_read, mem_write};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    n_vec++;
    if (st !== 6'b000000) begin
      n_err++; $display("FAIL reset_status got=%b want=%b", st, 6'b000000);
    end
    n_vec++;
    if ({mem_addr, mem_wdata, rdata0, rdata1} !== 64'h0) begin
      n_err++; $display("FAIL reset_data got=%h want=0", {mem_addr, mem_wdata, rdata0, rdata1});
    end
  endtask

  task automatic test_read();
    req0 = 1; we0 = 0; addr0 = 16'd20;
    tick();
    req0 = 0;
    n_vec++;
    if (st !== 6'b100010) begin
      n_err++; $display("FAIL read_access got=%b want=%b", st, 6'b100010);
    end
    n_vec++;
    if (mem_addr !== 16'd20) begin
      n_err++; $display("FAIL read_addr got=%0d want=20", mem_addr);
    end
    tick();
    n_vec++;
    if (st !== 6'b101000) begin
      n_err++; $display("FAIL read_done got=%b want=%b", st, 6'b101000);
    end
    n_vec++;
    if (rdata0 !== 16'd10) begin
      n_err++; $display("FAIL read_rdata0 got=%0d want=10", rdata0);
    end
    tick();
    n_vec++;
    if (st !== 6'b000000 || rdata0 !== 16'd10) begin
      n_err++; $display("FAIL read_idle st=%b rdata0=%0d want st=000000 rdata0=10", st, rdata0);
    end
  endtask

  task automatic test_write_read();
    req1 = 1; we1 = 1; addr1 = 16'd20; wdata1 = 16'd12;
    tick();
    req1 = 0;
    n_vec++;
    if (st !== 6'b010001 || mem_wdata !== 16'd12) begin
      n_err++; $display("FAIL wr_access st=%b wdata=%0d want st=010001 wdata=12", st, mem_wdata);
    end
    tick();
    n_vec++;
    if (st !== 6'b010100 || tb_mem[20] !== 16'd12) begin
      n_err++; $display("FAIL wr_done st=%b mem20=%0d want st=010100 mem20=12", st, tb_mem[20]);
    end
    n_vec++;
    if (rdata1 !== 16'd0) begin
      n_err++; $display("FAIL wr_rdata1 got=%0d want=0", rdata1);
    end
    tick();
    req0 = 1; we0 = 0; addr0 = 16'd20;
    tick();
    req0 = 0;
    tick();
    n_vec++;
    if (st !== 6'b101000 || rdata0 !== 16'd12 || rdata1 !== 16'd0) begin
      n_err++; $display("FAIL wr_readback st=%b rdata0=%0d rdata1=%0d want st=101000 rdata0=12 rdata1=0",
                        st, rdata0, rdata1);
    end
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] want;
    tb_mem[21] = 16'h0077;
    req0 = 1; we0 = 0; addr0 = 16'd20;
    req1 = 1; we1 = 0; addr1 = 16'd21;
    rst = 1;
    tick();
    rst = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      case (k % 6)
        1, 2:    want = 2'b10;
        4, 5:    want = 2'b01;
        default: want = 2'b00;
      endcase
      n_vec++;
      if ({gnt0, gnt1} !== want) begin
        n_err++; $display("FAIL contention_k%0d gnt=%b want=%b", k, {gnt0, gnt1}, want);
      end
    end
    n_vec++;
    if (rdata0 !== 16'd12 || rdata1 !== 16'h0077) begin
      n_err++; $display("FAIL contention_rdata rdata0=%h rdata1=%h want 000c 0077", rdata0, rdata1);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_write();
    tb_mem[20] = 16'd10;
    do_reset();
    req0 = 1; we0 = 1; addr0 = 16'd20; wdata0 = 16'd99;
    tick();
    req0 = 0;
    n_vec++;
    if (st !== 6'b100001) begin
      n_err++; $display("FAIL rstmid_access got=%b want=%b", st, 6'b100001);
    end
    rst = 1;
    #1;
    n_vec++;
    if (mem_write !== 1'b0) begin
      n_err++; $display("FAIL rstmid_gate mem_write=%b want=0", mem_write);
    end
    tick();
    rst = 0;
    n_vec++;
    if (st !== 6'b000000 || tb_mem[20] !== 16'd10) begin
      n_err++; $display("FAIL rstmid_abort st=%b mem20=%0d want st=000000 mem20=10", st, tb_mem[20]);
    end
    tick();
    n_vec++;
    if (done0 !== 1'b0) begin
      n_err++; $display("FAIL rstmid_nodone done0=%b want=0", done0);
    end
    req0 = 1; we0 = 0; addr0 = 16'd20;
    tick();
    req0 = 0;
    tick();
    n_vec++;
    if (rdata0 !== 16'd10) begin
      n_err++; $display("FAIL rstmid_readback rdata0=%0d want=10", rdata0);
    end
    tick();
  endtask

  task automatic test_early_drop();
    req1 = 1; we1 = 0; addr1 = 16'd20;
    tick();
    req1 = 0; addr1 = 16'd0;
    n_vec++;
    if (st !== 6'b010010 || mem_addr !== 16'd20) begin
      n_err++; $display("FAIL drop_access st=%b addr=%0d want st=010010 addr=20", st, mem_addr);
    end
    tick();
    n_vec++;
    if (st !== 6'b010100 || rdata1 !== 16'd10) begin
      n_err++; $display("FAIL drop_done st=%b rdata1=%0d want st=010100 rdata1=10", st, rdata1);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if (st !== 6'b000000) begin
        n_err++; $display("FAIL drop_idle_%0d st=%b want=000000", k, st);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = '0;
    tb_mem[20] = 16'd10;
    rst = 1;
    idle_inputs();
    test_reset();
    test_read();
    test_write_read();
    test_contention();
    test_reset_mid_write();
    test_early_drop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
